// File: rtl/conv_pkg.sv
// Shared FSM state encoding and column-half constants for the image load
// sequencer and its receptive-field position stepper.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam logic [3:0] COL_FIRST  = 4'd0;
  localparam logic [3:0] COL_SECOND = 4'd1;

endpackage

// File: rtl/rf_position_counter.sv
// Steps the receptive-field window position: column half 0 -> 1 on the same
// row, then back to half 0 on the next row; wraps to (0,0) after the last one.
module rf_position_counter
  import conv_pkg::*;
#(
  parameter int H = 8,
  parameter int F = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       clear,
  output logic [3:0] rowNumber,
  output logic [3:0] column,
  output logic       last
);

  localparam logic [3:0] LAST_ROW = 4'(H - F);

  logic [3:0] r_row;
  logic [3:0] r_col;

  assign rowNumber = r_row;
  assign column    = r_col;
  assign last      = (r_row == LAST_ROW) && (r_col == COL_SECOND);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_row <= 4'd0;
      r_col <= COL_FIRST;
    end else if (advance) begin
      if (r_col == COL_FIRST) begin
        r_col <= COL_SECOND;
      end else begin
        r_col <= COL_FIRST;
        r_row <= last ? 4'd0 : r_row + 4'd1;
      end
    end
  end

endmodule

// File: rtl/image_load_sequencer.sv
// Loads one D*H*W frame from a pixel stream, then sweeps the receptive-field
// positions for a downstream selector. Optional: IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN.
module image_load_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int D          = 1,
  parameter int H          = 8,
  parameter int W          = 8,
  parameter int F          = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pix_valid,
  input  logic [DATA_WIDTH-1:0]           pix_data,
  output logic                            pix_ready,
  output logic [0:D*H*W*DATA_WIDTH-1]     image,
  output logic [3:0]                      rowNumber,
  output logic [3:0]                      column,
  output logic                            sel_valid,
  input  logic                            sel_ready,
`ifdef IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN
  output logic [7:0]                      frame_count,
`endif
  output logic                            frame_done
);

  localparam int N_PIX    = D * H * W;
  localparam int CNT_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int IMG_BITS = N_PIX * DATA_WIDTH;
  localparam int IDX_W    = (IMG_BITS > 1) ? $clog2(IMG_BITS) : 1;

  seq_state_t             r_state;
  seq_state_t             w_nextState;
  logic [CNT_W-1:0]       r_pixCount;
  logic [0:IMG_BITS-1]    r_image;
  logic [IDX_W-1:0]       w_pixBase;
  logic                   w_pixXfer;
  logic                   w_lastPix;
  logic                   w_selXfer;
  logic                   w_lastPos;
  logic                   w_posClear;

  // Transfers are qualified by state directly so the handshakes never loop
  // back through the combinational ready/valid outputs.
  assign w_pixXfer  = pix_valid && (r_state == LOAD);
  assign w_selXfer  = sel_ready && (r_state == SWEEP);
  assign w_lastPix  = (r_pixCount == CNT_W'(N_PIX - 1));
  assign w_pixBase  = IDX_W'(r_pixCount) * IDX_W'(DATA_WIDTH);
  assign w_posClear = (r_state == LOAD);
  assign image      = r_image;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    pix_ready   = 1'b0;
    sel_valid   = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      LOAD: begin
        pix_ready = 1'b1;
        if (w_pixXfer && w_lastPix) w_nextState = SWEEP;
      end
      SWEEP: begin
        sel_valid = 1'b1;
        if (w_selXfer && w_lastPos) w_nextState = DONE;
      end
      DONE: begin
        frame_done  = 1'b1;
        w_nextState = LOAD;
      end
      default: w_nextState = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixCount <= '0;
    end else if (r_state != LOAD) begin
      r_pixCount <= '0;
    end else if (w_pixXfer) begin
      r_pixCount <= w_lastPix ? '0 : r_pixCount + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_image <= '0;
    end else if (w_pixXfer) begin
      r_image[w_pixBase +: DATA_WIDTH] <= pix_data;
    end
  end

  rf_position_counter #(
    .H (H),
    .F (F)
  ) u_position (
    .clk       (clk),
    .reset     (reset),
    .advance   (w_selXfer),
    .clear     (w_posClear),
    .rowNumber (rowNumber),
    .column    (column),
    .last      (w_lastPos)
  );

`ifdef IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN
  logic [7:0] r_frameCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameCount <= 8'd0;
    end else if (r_state == DONE) begin
      r_frameCount <= r_frameCount + 8'd1;
    end
  end

  assign frame_count = r_frameCount;
`endif

endmodule

// File: tb/tb_image_load_sequencer.sv
// Self-checking bench for image_load_sequencer: a pixel-array model plus the
// expected sweep order are built from plain loops and indices.
module tb_image_load_sequencer;

  localparam int DW       = 8;
  localparam int D        = 1;
  localparam int H        = 8;
  localparam int W        = 8;
  localparam int F        = 3;
  localparam int N_PIX    = D * H * W;
  localparam int IMG_BITS = N_PIX * DW;
  localparam int NUM_POS  = 2 * (H - F + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                pix_valid;
  logic [DW-1:0]       pix_data;
  logic                pix_ready;
  logic [0:IMG_BITS-1] image;
  logic [3:0]          rowNumber;
  logic [3:0]          column;
  logic                sel_valid;
  logic                sel_ready;
  logic                frame_done;
`ifdef IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN
  logic [7:0]          frame_count;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  refImg [0:N_PIX-1];
  int          expFrameCount = 0;

  always #5 clk = ~clk;

  image_load_sequencer #(
    .DATA_WIDTH (DW),
    .D          (D),
    .H          (H),
    .W          (W),
    .F          (F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .image       (image),
    .rowNumber   (rowNumber),
    .column      (column),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
`ifdef IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN
    .frame_count (frame_count),
`endif
    .frame_done  (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic sr);
    pix_valid = v;
    pix_data  = d;
    sel_ready = sr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkImage(input string tag);
    for (int i = 0; i < N_PIX; i++) begin
      checkOutput(tag, 32'(image[i*DW +: DW]), 32'(refImg[i]));
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < N_PIX; i++) refImg[i] = '0;
    expFrameCount = 0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
    checkOutput({tag, "_sel_valid"}, 32'(sel_valid), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_row"}, 32'(rowNumber), 32'd0);
    checkOutput({tag, "_col"}, 32'(column), 32'd0);
`ifdef IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN
    checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'(expFrameCount % 256));
`endif
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clearModel();
  endtask

  // mode 0: pixel index, mode 1: fixed value, mode 2: random
  task automatic loadFrame(input int mode, input logic [DW-1:0] fixedVal, input bit gaps, input int stopAfter);
    int n = 0;
    int cycles = 0;
    logic v;
    logic [DW-1:0] d;
    while (n < stopAfter && cycles < 2000) begin
      checkOutput("load_pix_ready", 32'(pix_ready), 32'd1);
      checkOutput("load_sel_valid", 32'(sel_valid), 32'd0);
      checkOutput("load_row", 32'(rowNumber), 32'd0);
      checkOutput("load_col", 32'(column), 32'd0);
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (mode)
        0:       d = n[DW-1:0];
        1:       d = fixedVal;
        default: d = DW'($urandom);
      endcase
      applyStimulus(v, d, 1'($urandom_range(0, 1)));
      tick();
      if (v) begin
        refImg[n] = d;
        n++;
      end
      cycles++;
    end
    checkOutput("load_transfers", 32'(n), 32'(stopAfter));
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic postLoadCheck();
    checkOutput("post_load_sel_valid", 32'(sel_valid), 32'd1);
    checkOutput("post_load_row", 32'(rowNumber), 32'd0);
    checkOutput("post_load_col", 32'(column), 32'd0);
    checkOutput("post_load_pix_ready", 32'(pix_ready), 32'd0);
    checkImage("post_load_image");
  endtask

  task automatic sweepFrame(input bit alwaysReady, input int stallIdx, input bit noisyPix);
    int idx = 0;
    int cycles = 0;
    int stall = 0;
    logic sr;
    while (idx < NUM_POS && cycles < 1000) begin
      checkOutput("sweep_sel_valid", 32'(sel_valid), 32'd1);
      checkOutput("sweep_row", 32'(rowNumber), 32'(idx / 2));
      checkOutput("sweep_col", 32'(column), 32'(idx % 2));
      checkOutput("sweep_pix_ready", 32'(pix_ready), 32'd0);
      checkOutput("sweep_frame_done", 32'(frame_done), 32'd0);
      if (idx == stallIdx && stall < 3) begin
        sr = 1'b0;
        stall++;
      end else begin
        sr = alwaysReady ? 1'b1 : 1'($urandom_range(0, 1));
      end
      applyStimulus(noisyPix, DW'($urandom), sr);
      tick();
      if (sr) idx++;
      cycles++;
    end
    checkOutput("sweep_positions", 32'(idx), 32'(NUM_POS));
    applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)));
    checkOutput("done_frame_done", 32'(frame_done), 32'd1);
    checkOutput("done_sel_valid", 32'(sel_valid), 32'd0);
    checkOutput("done_pix_ready", 32'(pix_ready), 32'd0);
    expFrameCount++;
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("after_done");
    checkImage("after_done_image");
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    clearModel();

    $display("[TB] reset state");
    doReset();
    checkIdle("reset");
    checkImage("reset_image");

    $display("[TB] ramp frame, continuous ready");
    loadFrame(0, '0, 1'b0, N_PIX);
    postLoadCheck();
    checkOutput("ramp_first_px", 32'(image[0:7]), 32'd0);
    checkOutput("ramp_last_px", 32'(image[IMG_BITS-8:IMG_BITS-1]), 32'd63);
    sweepFrame(1'b1, -1, 1'b0);

    $display("[TB] random frame with gaps, stall at (2,1)");
    loadFrame(2, '0, 1'b1, N_PIX);
    postLoadCheck();
    sweepFrame(1'b1, 5, 1'b0);

    $display("[TB] reset mid-load then fixed 0xAA frame");
    loadFrame(2, '0, 1'b0, 30);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    clearModel();
    checkIdle("mid_load_reset");
    checkImage("mid_load_reset_image");
    loadFrame(1, 8'hAA, 1'b0, N_PIX);
    postLoadCheck();
    sweepFrame(1'b0, -1, 1'b0);

    $display("[TB] pixel traffic during sweep");
    loadFrame(2, '0, 1'b1, N_PIX);
    postLoadCheck();
    sweepFrame(1'b0, -1, 1'b1);

    $display("[TB] reset mid-sweep");
    loadFrame(2, '0, 1'b0, N_PIX);
    postLoadCheck();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
    end
    checkOutput("mid_sweep_row", 32'(rowNumber), 32'd1);
    checkOutput("mid_sweep_col", 32'(column), 32'd1);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    clearModel();
    checkIdle("mid_sweep_reset");
    checkImage("mid_sweep_reset_image");

    $display("[TB] back-to-back random frames");
    for (int f = 0; f < 2; f++) begin
      loadFrame(2, '0, 1'b1, N_PIX);
      postLoadCheck();
      sweepFrame(1'b0, -1, 1'b1);
    end

`ifdef IMAGE_LOAD_SEQUENCER_FRAME_COUNT_EN
    $display("[TB] frame counter wrap over 257 frames");
    doReset();
    checkIdle("count_reset");
    for (int f = 0; f < 257; f++) begin
      loadFrame(2, '0, 1'b0, N_PIX);
      sweepFrame(1'b1, -1, 1'b0);
    end
    checkOutput("frame_count_257", 32'(frame_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
